bitserial_alu_ctrl: RTL and testbench
=====================================

BITSERIAL_ALU_CTRL -- requirements
Module: bitserial_alu_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal range is 2 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a new operation is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-006 The block SHALL have ports a and b, each input, WIDTH bits: the operands.
REQ-007 The block SHALL have port op, input, 3 bits, with these codes: 000 ADD, 001 SUB, 010 XOR, 011 XOR (or SLT, see Configuration), 100 AND, 101 NAND, 110 NOR, 111 OR.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result and flags are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port result, output, WIDTH bits: the operation result.
REQ-011 The block SHALL have ports carry, overflow and zero, each output, 1 bit: the result flags.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, in_valid=1 SHALL latch a, b and op into shift registers, clear the bit counter, load the carry flop (1 for SUB/SLT, else 0), and go to RUN.
REQ-015 In RUN, each cycle SHALL process one bit, LSB first: operand b is inverted for SUB/SLT, a 1-bit slice computes the selected function, the result bit is shifted into result MSB-side, and the carry flop updates.
REQ-016 RUN SHALL last exactly WIDTH cycles, after which the FSM enters DONE; out_valid SHALL rise WIDTH+1 cycles after the accepting edge.
REQ-017 carry SHALL equal the carry-out of the MSB for ADD/SUB/SLT, and 0 for logic ops.
REQ-018 overflow SHALL equal the carry-into-MSB XOR the carry-out-of-MSB for ADD/SUB/SLT, and 0 for logic ops.
REQ-019 zero SHALL be 1 exactly when the final result equals 0, tracked serially and with no post-pass.
REQ-020 In DONE, result and flags SHALL remain stable until out_valid and out_ready are both 1, then the FSM SHALL return to IDLE; the next operation can be accepted no earlier than the following cycle.
REQ-021 in_valid asserted outside IDLE SHALL be ignored, with no queueing.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 Arithmetic SHALL wrap modulo 2^WIDTH; there are no exceptions and no stall on overflow.
REQ-024 Operand inputs SHALL be sampled only on the accepting edge; later changes to them SHALL not affect an operation in progress.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, result=0, carry=0, overflow=0, zero=1, with the counter and carry flop at 0.
REQ-026 Reset asserted mid-RUN or mid-DONE SHALL abort the operation and discard the result, with no output pulse.
REQ-027 After rst_n rises, the first operation SHALL be acceptable on the first rising edge.

Configuration
REQ-028 The block SHALL have the macro BITSERIAL_ALU_SLT_EN.
REQ-029 With BITSERIAL_ALU_SLT_EN defined, op 011 SHALL be SLT: the block performs a serial a-b, result[WIDTH-1:1]=0, result[0]=(MSB of difference) XOR overflow, and carry, overflow and zero reflect the final result (carry=0, overflow=0).
REQ-030 Without BITSERIAL_ALU_SLT_EN, op 011 SHALL behave exactly as XOR, and no SLT logic SHALL be present.

Verification (WIDTH=32)
REQ-031 The bench SHALL cover: ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, carry 0, overflow 1, zero 0, out_valid at cycle 33.
REQ-032 The bench SHALL cover: SUB a=5, b=5 -> result 0, carry 1, overflow 0, zero 1.
REQ-033 The bench SHALL cover: NOR a=0, b=0 -> result 0xFFFFFFFF, carry 0, overflow 0; and AND a=0xF0F0F0F0, b=0x0F0F0F0F -> result 0, zero 1.
REQ-034 The bench SHALL cover: hold out_ready=0 for 10 cycles in DONE -> result and flags stable, in_ready 0, a new in_valid ignored; then out_ready=1 -> IDLE next cycle.
REQ-035 The bench SHALL cover: rst_n pulsed low at RUN bit 15 -> outputs at their reset values immediately, no out_valid, and a new ADD 2+3 then yields 5.
REQ-036 The bench SHALL cover: with BITSERIAL_ALU_SLT_EN, op 011 a=0xFFFFFFFF(-1), b=1 -> result 1; a=0x80000000, b=1 -> result 1 (overflow case); without the macro, op 011 a=0xFFFFFFFF, b=1 -> result 0xFFFFFFFE.

Source files
------------

// File: rtl/bitserial_alu_ctrl.sv
// bitserial_alu_ctrl: LSB-first bit-serial ALU with valid/ready handshake on both sides.
// Optional SLT on op 011 when BITSERIAL_ALU_SLT_EN is defined; otherwise op 011 is XOR.
module bitserial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, cm_q, cm_d, cy_q, cy_d, ov_q, ov_d, z_q, z_d;
    logic             inv_in, inv, arith, ab, bb, sum, cout, rbit;

`ifdef BITSERIAL_ALU_SLT_EN
    logic slt, lt;
    assign slt    = op_q == 3'b011;
    assign inv_in = op == 3'b001 || op == 3'b011;
    assign inv    = op_q == 3'b001 || slt;
    assign arith  = op_q[2:1] == 2'b00 || slt;
    // signed less-than: sign of the difference corrected by overflow
    assign lt     = res_q[WIDTH-1] ^ c_q ^ cm_q;
`else
    assign inv_in = op == 3'b001;
    assign inv    = op_q == 3'b001;
    assign arith  = op_q[2:1] == 2'b00;
`endif

    assign ab   = a_q[0];
    assign bb   = b_q[0] ^ inv;
    assign sum  = ab ^ bb ^ c_q;
    assign cout = (ab & bb) | (c_q & (ab ^ bb));

    always_comb begin
        rbit = 1'b0;
        case (op_q)
            3'b000, 3'b001, 3'b010, 3'b011: rbit = arith ? sum : ab ^ bb;
            3'b100:                         rbit = ab & bb;
            3'b101:                         rbit = ~(ab & bb);
            3'b110:                         rbit = ~(ab | bb);
            default:                        rbit = ab | bb;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        c_d       = c_q;
        cm_d      = cm_q;
        cy_d      = cy_q;
        ov_d      = ov_q;
        z_d       = z_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    res_d   = '0;
                    cnt_d   = '0;
                    c_d     = inv_in;
                    cm_d    = 1'b0;
                    cy_d    = 1'b0;
                    ov_d    = 1'b0;
                    z_d     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(WIDTH)) begin
                    // all bits done: c_q is MSB carry-out, cm_q is MSB carry-in
                    cy_d    = arith & c_q;
                    ov_d    = arith & (c_q ^ cm_q);
                    state_d = DONE;
`ifdef BITSERIAL_ALU_SLT_EN
                    if (slt) begin
                        res_d = {{(WIDTH-1){1'b0}}, lt};
                        z_d   = ~lt;
                        cy_d  = 1'b0;
                        ov_d  = 1'b0;
                    end
`endif
                end else begin
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    res_d = {rbit, res_q[WIDTH-1:1]};
                    cm_d  = c_q;
                    c_d   = cout;
                    z_d   = z_q & ~rbit;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cm_q    <= 1'b0;
            cy_q    <= 1'b0;
            ov_q    <= 1'b0;
            z_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cm_q    <= cm_d;
            cy_q    <= cy_d;
            ov_q    <= ov_d;
            z_q     <= z_d;
        end
    end

    assign result   = res_q;
    assign carry    = cy_q;
    assign overflow = ov_q;
    assign zero     = z_q;
endmodule

// File: tb/tb_bitserial_alu_ctrl.sv
// tb_bitserial_alu_ctrl: directed vectors plus a per-cycle arithmetic reference model.
module tb_bitserial_alu_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [2:0]   op = '0;
    logic         in_ready, out_valid, carry, overflow, zero;
    logic [W-1:0] result;
    int           checks = 0, fails = 0;

    bitserial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // {result, carry, overflow, zero} from plain integer arithmetic
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (o)
            3'd0: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[W-1:0];
                c = s[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd1: begin
                s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
                r = s[W-1:0];
                c = s[W];
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
`ifdef BITSERIAL_ALU_SLT_EN
            3'd3: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
`else
            3'd3: r = x ^ y;
`endif
            3'd2: r = x ^ y;
            3'd4: r = x & y;
            3'd5: r = ~(x & y);
            3'd6: r = ~(x | y);
            default: r = x | y;
        endcase
        return {r, c, v, r == '0};
    endfunction

    int             m_phase = 0, m_cnt = 0;
    logic [W+2:0]   m_pend = '0, m_out = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_cnt   <= 0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_pend  <= model(a, b, op);
                m_phase <= 1;
                m_cnt   <= 0;
            end
        end else if (m_phase == 1) begin
            if (m_cnt == W) begin
                m_phase <= 2;
                m_out   <= m_pend;
            end else m_cnt <= m_cnt + 1;
        end else if (out_ready) m_phase <= 0;
    end

    always @(negedge clk) begin
        chk("cyc in_ready", in_ready, m_phase == 0);
        chk("cyc out_valid", out_valid, m_phase == 2);
        if (m_phase == 2) begin
            chk("cyc result", result, m_out[W+2:3]);
            chk("cyc carry", carry, m_out[2]);
            chk("cyc overflow", overflow, m_out[1]);
            chk("cyc zero", zero, m_out[0]);
        end
    end

    task automatic chk_reset(input string n);
        chk({n, " result"}, result, 0);
        chk({n, " carry"}, carry, 0);
        chk({n, " overflow"}, overflow, 0);
        chk({n, " zero"}, zero, 1);
        chk({n, " in_ready"}, in_ready, 1);
        chk({n, " out_valid"}, out_valid, 0);
    endtask

    // called #1 after a rising edge with the block idle; returns the same way
    task automatic run_op(input string n, input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o,
                          input logic [W-1:0] er, input logic ec, input logic eo, input logic ez, input bit hold);
        int cyc;
        a = x;
        b = y;
        op = o;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 3'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({n, " latency"}, cyc, W + 1);
        chk({n, " result"}, result, er);
        chk({n, " carry"}, carry, ec);
        chk({n, " overflow"}, overflow, eo);
        chk({n, " zero"}, zero, ez);
        if (hold) begin
            repeat (10) begin
                in_valid = 1'b1;
                a = $urandom;
                b = $urandom;
                @(posedge clk); #1;
                chk({n, " hold result"}, result, er);
                chk({n, " hold flags"}, {carry, overflow, zero}, {ec, eo, ez});
                chk({n, " hold in_ready"}, in_ready, 0);
                chk({n, " hold out_valid"}, out_valid, 1);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({n, " back idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        run_op("add_ovf", 32'h7FFFFFFF, 32'h1, 3'd0, 32'h80000000, 0, 1, 0, 0);
        run_op("sub_eq", 32'd5, 32'd5, 3'd1, 32'h0, 1, 0, 1, 0);
        run_op("nor_00", 32'h0, 32'h0, 3'd6, 32'hFFFFFFFF, 0, 0, 0, 0);
        run_op("and_0", 32'hF0F0F0F0, 32'h0F0F0F0F, 3'd4, 32'h0, 0, 0, 1, 0);
        run_op("add_wrap", 32'hFFFFFFFF, 32'h1, 3'd0, 32'h0, 1, 0, 1, 0);
        run_op("sub_neg", 32'd3, 32'd5, 3'd1, 32'hFFFFFFFE, 0, 0, 0, 0);
        run_op("sub_ovf", 32'h80000000, 32'h1, 3'd1, 32'h7FFFFFFF, 1, 1, 0, 0);
        run_op("or", 32'h12340000, 32'h00005678, 3'd7, 32'h12345678, 0, 0, 0, 0);
        run_op("xor", 32'hA5A5A5A5, 32'hFFFF0000, 3'd2, 32'h5A5AA5A5, 0, 0, 0, 0);
        run_op("nand", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5, 32'h0, 0, 0, 1, 0);
        run_op("hold", 32'h00001000, 32'h00000234, 3'd0, 32'h00001234, 0, 0, 0, 1);
`ifdef BITSERIAL_ALU_SLT_EN
        run_op("slt_m1", 32'hFFFFFFFF, 32'h1, 3'd3, 32'h1, 0, 0, 0, 0);
        run_op("slt_ovf", 32'h80000000, 32'h1, 3'd3, 32'h1, 0, 0, 0, 0);
        run_op("slt_ge", 32'h5, 32'h5, 3'd3, 32'h0, 0, 0, 1, 0);
`else
        run_op("op3_xor", 32'hFFFFFFFF, 32'h1, 3'd3, 32'hFFFFFFFE, 0, 0, 0, 0);
`endif
        a = 32'h0000FFFF;
        b = 32'h00000001;
        op = 3'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("midrun reset");
        repeat (3) begin
            @(posedge clk); #1;
            chk("reset no out_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        run_op("add_after_rst", 32'd2, 32'd3, 3'd0, 32'd5, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
